// File: rtl/life_run_ctrl.sv
// rtl/life_run_ctrl.sv - run/pause/step/speed controller for a Game of Life generation engine
// Define LIFE_GEN_COUNT_EN to build the completed-generation counter; otherwise gen_count is tied to zero.
module life_run_ctrl #(
    parameter int unsigned BASE_DIV    = 1_500_000,
    parameter int unsigned RESET_SPEED = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  usr_op,
    input  logic        gen_done,
    output logic        gen_req,
    output logic        running,
    output logic [2:0]  speed,
    output logic [15:0] gen_count
);

    typedef enum logic [1:0] {
        PAUSE    = 2'd0,
        RUN_WAIT = 2'd1,
        RUN_REQ  = 2'd2,
        STEP_REQ = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [3:0]  op_edge;
    logic        run_edge, step_edge, up_edge, dn_edge;
    logic [2:0]  speed_q, speed_d;
    logic        speed_chg;
    logic [31:0] tick_q, tick_d;
    logic [31:0] period_m1;
    logic        pause_pend_q, pause_pend_d;

    assign op_edge   = usr_op & ~op_q;
    assign run_edge  = op_edge[0];
    assign step_edge = op_edge[1];
    assign up_edge   = op_edge[2];
    assign dn_edge   = op_edge[3];

    // Opposing speed edges in one cycle cancel out.
    always_comb begin
        speed_d = speed_q;
        if (up_edge && !dn_edge && speed_q != 3'd7) begin
            speed_d = speed_q + 3'd1;
        end else if (dn_edge && !up_edge && speed_q != 3'd0) begin
            speed_d = speed_q - 3'd1;
        end
    end

    assign speed_chg = (speed_d != speed_q);
    assign period_m1 = (32'(BASE_DIV) << (3'd7 - speed_q)) - 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PAUSE;
            op_q         <= usr_op;
            speed_q      <= 3'(RESET_SPEED);
            tick_q       <= 32'd0;
            pause_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= usr_op;
            speed_q      <= speed_d;
            tick_q       <= tick_d;
            pause_pend_q <= pause_pend_d;
        end
    end

    // gen_done only counts in the request states, so a stale pulse elsewhere is harmless.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PAUSE: begin
                if (run_edge) begin
                    state_d = RUN_WAIT;
                end else if (step_edge) begin
                    state_d = STEP_REQ;
                end
            end
            RUN_WAIT: begin
                if (run_edge) begin
                    state_d = PAUSE;
                end else if (!speed_chg && tick_q >= period_m1) begin
                    state_d = RUN_REQ;
                end
            end
            RUN_REQ: begin
                if (gen_done) begin
                    state_d = (pause_pend_q || run_edge) ? PAUSE : RUN_WAIT;
                end
            end
            STEP_REQ: begin
                if (gen_done) begin
                    state_d = PAUSE;
                end
            end
            default: state_d = PAUSE;
        endcase
    end

    // Every state change and every effective speed change restarts the period.
    always_comb begin
        tick_d = tick_q;
        if (state_d != state_q || speed_chg) begin
            tick_d = 32'd0;
        end else if (state_q == RUN_WAIT) begin
            tick_d = tick_q + 32'd1;
        end
    end

    always_comb begin
        pause_pend_d = 1'b0;
        if (state_q == RUN_REQ && state_d == RUN_REQ) begin
            pause_pend_d = pause_pend_q | run_edge;
        end
    end

    always_comb begin
        gen_req = 1'b0;
        running = 1'b0;
        case (state_q)
            RUN_WAIT: running = 1'b1;
            RUN_REQ: begin
                running = 1'b1;
                gen_req = 1'b1;
            end
            STEP_REQ: gen_req = 1'b1;
            default: begin
                gen_req = 1'b0;
                running = 1'b0;
            end
        endcase
    end

    assign speed = speed_q;

`ifdef LIFE_GEN_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'h0000;
        end else if (gen_done && gen_req) begin
            count_q <= count_q + 16'h0001;
        end
    end

    assign gen_count = count_q;
`else
    assign gen_count = 16'h0000;
`endif

endmodule

// File: tb/tb_life_run_ctrl.sv
// tb/tb_life_run_ctrl.sv - directed self-checking bench for life_run_ctrl
// Expected gen_count follows LIFE_GEN_COUNT_EN: a running model when defined, zero otherwise.
module tb_life_run_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  usr_op;
    logic        gen_done;
    logic        gen_req;
    logic        running;
    logic [2:0]  speed;
    logic [15:0] gen_count;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_cnt;
    int          cyc;

    life_run_ctrl #(
        .BASE_DIV    (4),
        .RESET_SPEED (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .usr_op    (usr_op),
        .gen_done  (gen_done),
        .gen_req   (gen_req),
        .running   (running),
        .speed     (speed),
        .gen_count (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_gc();
`ifdef LIFE_GEN_COUNT_EN
        return {16'h0000, exp_cnt};
`else
        return 32'h0;
`endif
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Button held for one edge then released for one edge.
    task automatic press(input logic [3:0] bits);
        usr_op = bits;
        tick(1);
        usr_op = 4'b0000;
        tick(1);
    endtask

    task automatic wait_req(input int max, output int cycles);
        cycles = 0;
        while (!gen_req && cycles < max) begin
            tick(1);
            cycles++;
        end
    endtask

    // Datapath answer: gen_done two cycles after gen_req is seen high.
    task automatic do_done();
        tick(1);
        check("req_held", gen_req, 1);
        gen_done = 1'b1;
        tick(1);
        gen_done = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic count_req(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (gen_req) hi++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 16'd0;
        rst      = 1'b1;
        usr_op   = 4'b0000;
        gen_done = 1'b0;
        tick(3);
        check("rst_req", gen_req, 0);
        check("rst_running", running, 0);
        check("rst_speed", speed, 7);
        check("rst_count", gen_count, exp_gc());
        rst = 1'b0;
        tick(2);

        // Run: first request 3 edges after press, then every 4.
        press(4'b0001);
        check("run_running", running, 1);
        check("run_req_low", gen_req, 0);
        wait_req(60, cyc);
        check("run_first_period", cyc, 3);
        for (int g = 0; g < 3; g++) begin
            do_done();
            check("run_req_drop", gen_req, 0);
            check("run_still_running", running, 1);
            if (g < 2) begin
                wait_req(60, cyc);
                check("run_period", cyc, 4);
            end
        end
        check("run_count3", gen_count, exp_gc());

        // Pause while a request is in flight.
        wait_req(60, cyc);
        check("pif_period", cyc, 4);
        press(4'b0001);
        check("pif_req_held", gen_req, 1);
        check("pif_running", running, 1);
        tick(2);
        check("pif_req_held2", gen_req, 1);
        do_done();
        check("pif_paused", running, 0);
        check("pif_req_low", gen_req, 0);
        check("pif_count", gen_count, exp_gc());
        count_req(20, cyc);
        check("pif_no_more_req", cyc, 0);

        // Single step from pause.
        press(4'b0010);
        check("step_req", gen_req, 1);
        check("step_running", running, 0);
        do_done();
        check("step_req_low", gen_req, 0);
        check("step_running_after", running, 0);
        check("step_count", gen_count, exp_gc());
        count_req(10, cyc);
        check("step_exactly_one", cyc, 0);

        // Step while running is ignored.
        press(4'b0001);
        press(4'b0010);
        check("step_ign_running", running, 1);
        wait_req(60, cyc);
        check("step_ign_period", cyc, 1);
        check("step_ign_running2", running, 1);
        do_done();
        press(4'b0001);
        check("step_ign_paused", running, 0);

        // Speed change restarts the period counter.
        press(4'b0001);
        press(4'b1000);
        check("chg_speed6", speed, 6);
        wait_req(60, cyc);
        check("chg_period_restart", cyc, 7);
        do_done();
        press(4'b0001);
        press(4'b0100);
        check("chg_speed_back7", speed, 7);

        // Saturation at both ends; slowest period is 512.
        press(4'b0100);
        check("sat_top", speed, 7);
        press(4'b1000);
        check("sat_dn1", speed, 6);
        for (int k = 0; k < 7; k++) press(4'b1000);
        check("sat_bottom", speed, 0);
        press(4'b1000);
        check("sat_bottom_hold", speed, 0);
        press(4'b0001);
        wait_req(700, cyc);
        check("sat_period512", cyc, 511);
        do_done();
        press(4'b0001);
        for (int k = 0; k < 7; k++) press(4'b0100);
        check("sat_restore7", speed, 7);

        // Simultaneous edges.
        press(4'b1100);
        check("sim_updn_at7", speed, 7);
        press(4'b1000);
        press(4'b1100);
        check("sim_updn_at6", speed, 6);
        press(4'b0100);
        check("sim_restore7", speed, 7);
        press(4'b0011);
        check("sim_runstep_running", running, 1);
        check("sim_runstep_noreq", gen_req, 0);
        wait_req(60, cyc);
        check("sim_runstep_period", cyc, 3);
        do_done();
        press(4'b0001);

        // Reset mid-request at speed 5, button held through reset.
        press(4'b1000);
        press(4'b1000);
        check("mid_speed5", speed, 5);
        press(4'b0001);
        wait_req(60, cyc);
        check("mid_period16", cyc, 15);
        rst    = 1'b1;
        usr_op = 4'b0001;
        tick(1);
        exp_cnt = 16'd0;
        check("mid_req_drop", gen_req, 0);
        check("mid_running", running, 0);
        check("mid_speed_reset", speed, 7);
        check("mid_count_reset", gen_count, exp_gc());
        rst = 1'b0;
        tick(3);
        check("held_btn_no_cmd", running, 0);
        gen_done = 1'b1;
        tick(1);
        gen_done = 1'b0;
        tick(1);
        check("stale_done_req", gen_req, 0);
        check("stale_done_running", running, 0);
        check("stale_done_count", gen_count, exp_gc());
        usr_op = 4'b0000;
        tick(1);
        press(4'b0001);
        check("post_reset_run", running, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/life_run_ctrl.md
LIFE_RUN_CTRL -- requirements
Module: life_run_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  BASE_DIV, 1_500_000, generation period in clk cycles at fastest speed (speed 7); minimum 2.
  RESET_SPEED, 4, speed level loaded on reset (0..7).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
  clk  input  1  single system clock; all logic on its rising edge.
  rst  input  1  synchronous, active-high reset.
  usr_op  input  4  debounced button levels: [0] run/pause, [1] single step, [2] speed up, [3] speed down.
  gen_done  input  1  one-cycle pulse from the cell-update datapath: the requested generation is finished.
  gen_req  output  1  generation request; held high until gen_done.
  running  output  1  high while in RUN mode, including a RUN-mode generation in flight.
  speed  output  3  current speed level; 0 slowest, 7 fastest.
  gen_count  output  16  count of completed generations.

Function
REQ-003 Each usr_op bit SHALL be edge-detected against a registered copy, and only a 0->1 transition SHALL act as a command.
REQ-004 The FSM SHALL have the states PAUSE, RUN_WAIT, RUN_REQ and STEP_REQ.
REQ-005 PAUSE: a run/pause edge -> RUN_WAIT with tick counter cleared; a step edge -> STEP_REQ.
REQ-006 RUN_WAIT: the tick counter SHALL count 0..P-1, where P = BASE_DIV << (7 - speed) is held in a 32-bit counter; at P-1 -> RUN_REQ and counter cleared; a run/pause edge -> PAUSE.
REQ-007 RUN_REQ and STEP_REQ SHALL drive gen_req = 1; on gen_done, RUN_REQ -> RUN_WAIT (or PAUSE if a pause is pending) and STEP_REQ -> PAUSE.
REQ-008 A run/pause edge during RUN_REQ SHALL set pause_pending; the request still completes, and pause_pending clears when the FSM leaves RUN_REQ.
REQ-009 A run/pause edge during STEP_REQ, and a step edge in any state other than PAUSE, SHALL be ignored.
REQ-010 gen_req SHALL rise 1 cycle after the state entry decision and fall in the cycle after gen_done is sampled; gen_req SHALL never pulse back-to-back without gen_done in between.
REQ-011 gen_done arriving while gen_req = 0 SHALL be ignored, with no state or counter change.
REQ-012 A speed-up edge SHALL increment speed, saturating at 7; a speed-down edge SHALL decrement speed, saturating at 0.
REQ-013 If both speed edges occur in the same cycle, speed SHALL stay unchanged.
REQ-014 Any effective speed change SHALL clear the tick counter, so the new period applies from that cycle.
REQ-015 If run/pause and step edges occur in the same cycle, run/pause SHALL win and step SHALL be dropped.
REQ-016 gen_count SHALL increment on each accepted gen_done and wrap from 0xFFFF to 0x0000.
REQ-017 running SHALL be 1 in RUN_WAIT and RUN_REQ, and 0 otherwise.

Reset
REQ-018 While rst = 1 at a clk edge, the block SHALL load: state = PAUSE, gen_req = 0, running = 0, speed = RESET_SPEED, gen_count = 0, tick counter = 0, pause_pending = 0, and edge registers = current usr_op.
REQ-019 Loading the edge registers from usr_op SHALL ensure a button held through reset produces no command.
REQ-020 Reset asserted with a request in flight SHALL drop gen_req in the next cycle, and a later stale gen_done SHALL be ignored per REQ-011.

Configuration
REQ-021 With macro LIFE_GEN_COUNT_EN defined, gen_count SHALL behave per REQ-016.
REQ-022 Without LIFE_GEN_COUNT_EN, gen_count SHALL be tied to 16'h0000 and no counter register SHALL be synthesized.

Verification
REQ-023 The bench SHALL cover the following scenarios, with BASE_DIV = 4 and RESET_SPEED = 7:
  Run: after reset, pulse usr_op[0] -> gen_req rises every 4 cycles plus handshake; with gen_done returned 2 cycles after gen_req, gen_count = 3 after 3 done pulses.
  Pause in flight: usr_op[0] edge while gen_req = 1 -> gen_req held until gen_done, then state PAUSE, running = 0, no further gen_req.
  Step: in PAUSE, usr_op[1] edge -> exactly one gen_req; after gen_done, gen_count increments by 1 and running stays 0; a step edge while running -> no effect.
  Speed saturation: at speed 7, usr_op[2] edge -> speed = 7; then 8 usr_op[3] edges -> speed = 0, and the period becomes 512 cycles.
  Simultaneous edges: usr_op = 4'b1100 from 4'b0000 -> speed unchanged; usr_op = 4'b0011 in PAUSE -> RUN_WAIT and no step request.
  Reset mid-request: assert rst with gen_req = 1 -> gen_req = 0, speed = 7 and gen_count = 0; a later gen_done is ignored; with LIFE_GEN_COUNT_EN undefined, gen_count stays 0 throughout.
